ram_arbiter: RTL and testbench

Two-port arbiter sharing the single-port 32x8 RAM between two requesters. Each requester issues read or write transactions over a valid/ready handshake. The arbiter grants one transaction at a time, sequences the RAM control lines, waits out the RAM read latency and returns a response pulse to the winning requester. It sits directly in front of the RAM instance; requesters never drive RAM pins.

---
 rtl/ram_arb_pkg.sv | 15 +
 rtl/rr_arbiter2.sv | 37 +++
 rtl/ram_arbiter.sv | 109 ++++++++++
 tb/tb_ram_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester RAM arbiter.
package ram_arb_pkg;

    localparam int unsigned NREQ   = 2;
    localparam int unsigned DEF_AW = 5;
    localparam int unsigned DEF_DW = 8;
    localparam int unsigned LAT_W  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way arbiter producing a one-hot grant from the request vector.
// Build option: RAM_ARB_FIXED_PRIO_EN selects fixed priority (requester 0 first).
module rr_arbiter2
    import ram_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic            last,
    output logic [NREQ-1:0] grant_c
);

`ifdef RAM_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = last;

    // Requester 0 always wins a tie.
    always_comb begin
        grant_c = '0;
        if (req[0]) begin
            grant_c = 2'b01;
        end else if (req[1]) begin
            grant_c = 2'b10;
        end
    end
`else
    // On a tie, grant the requester that was not granted last.
    always_comb begin
        grant_c = '0;
        case (req)
            2'b01:   grant_c = 2'b01;
            2'b10:   grant_c = 2'b10;
            2'b11:   grant_c = last ? 2'b01 : 2'b10;
            default: grant_c = '0;
        endcase
    end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between two valid/ready requesters.
// Build option: RAM_ARB_FIXED_PRIO_EN replaces round-robin with fixed priority.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned AW     = DEF_AW,
    parameter int unsigned DW     = DEF_DW,
    parameter int unsigned RD_LAT = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wdata,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [DW-1:0]        rsp_rdata,
    output logic                 ram_wena,
    output logic [AW-1:0]        ram_addr,
    output logic [DW-1:0]        ram_wdata,
    input  logic [DW-1:0]        ram_rdata
);

    state_t            state;
    logic              win_id;
    logic              lat_we;
    logic [LAT_W-1:0]  cnt;
    logic              last_grant;
    logic [NREQ-1:0]   grant_c;
    logic [NREQ-1:0]   hs;
    logic              hs_id;
    logic [AW-1:0]     sel_addr;
    logic [DW-1:0]     sel_wdata;

    assign hs        = req_valid & req_ready;
    assign hs_id     = hs[1];
    assign sel_addr  = hs_id ? req_addr[AW +: AW]   : req_addr[0 +: AW];
    assign sel_wdata = hs_id ? req_wdata[DW +: DW] : req_wdata[0 +: DW];

`ifdef RAM_ARB_FIXED_PRIO_EN
    assign last_grant = 1'b1;
`endif

    rr_arbiter2 u_arb (
        .req     (req_valid),
        .last    (last_grant),
        .grant_c (grant_c)
    );

    // Transaction sequencer: accept, drive RAM, wait read latency, respond.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            ram_wena   <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            win_id     <= 1'b0;
            lat_we     <= 1'b0;
            cnt        <= '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
            last_grant <= 1'b1;
`endif
        end else begin
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (|hs) begin
                        win_id    <= hs_id;
                        lat_we    <= req_we[hs_id];
                        ram_wena  <= req_we[hs_id];
                        ram_addr  <= sel_addr;
                        ram_wdata <= sel_wdata;
                        cnt       <= LAT_W'(RD_LAT);
                        req_ready <= '0;
                        state     <= ACCESS;
`ifndef RAM_ARB_FIXED_PRIO_EN
                        last_grant <= hs_id;
`endif
                    end else begin
                        req_ready <= grant_c;
                    end
                end
                ACCESS: begin
                    if (lat_we || cnt == '0) begin
                        ram_wena          <= 1'b0;
                        rsp_rdata         <= lat_we ? '0 : ram_rdata;
                        rsp_valid[win_id] <= 1'b1;
                        state             <= RESP;
                    end else begin
                        cnt <= cnt - LAT_W'(1);
                    end
                end
                RESP: begin
                    rsp_rdata <= '0;
                    req_ready <= grant_c;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter (RD_LAT=0 and RD_LAT=2 instances).
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    // RD_LAT = 0 instance
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_we = '0;
    logic [9:0]  req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        ram_wena;
    logic [4:0]  ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    // RD_LAT = 2 instance
    logic [1:0]  b_valid = '0;
    logic [1:0]  b_we = '0;
    logic [9:0]  b_addr = '0;
    logic [15:0] b_wdata = '0;
    logic [1:0]  b_ready;
    logic [1:0]  b_rsp_valid;
    logic [7:0]  b_rsp_rdata;
    logic        b_ram_wena;
    logic [4:0]  b_ram_addr;
    logic [7:0]  b_ram_wdata;
    logic [7:0]  b_ram_rdata;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_arbiter #(.AW(5), .DW(8), .RD_LAT(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ram_wena(ram_wena), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    ram_arbiter #(.AW(5), .DW(8), .RD_LAT(2)) b_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
        .req_addr(b_addr), .req_wdata(b_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
        .ram_wena(b_ram_wena), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata),
        .ram_rdata(b_ram_rdata)
    );

    // Zero-latency RAM model, preloaded with a per-address pattern.
    logic [7:0] mem0 [32];
    bit         mem0_init = 1'b0;
    always @(posedge clk) begin
        if (!mem0_init) begin
            for (int i = 0; i < 32; i++) mem0[i] <= 8'(i) ^ 8'hA5;
            mem0_init <= 1'b1;
        end else if (ram_wena) begin
            mem0[ram_addr] <= ram_wdata;
        end
    end
    assign ram_rdata = mem0[ram_addr];

    // Two-cycle read-latency RAM model.
    logic [7:0] mem2 [32];
    logic [7:0] p1 = '0;
    logic [7:0] p2 = '0;
    bit         mem2_init = 1'b0;
    always @(posedge clk) begin
        if (!mem2_init) begin
            for (int i = 0; i < 32; i++) mem2[i] <= 8'(i) ^ 8'h5A;
            mem2_init <= 1'b1;
        end else begin
            if (b_ram_wena) mem2[b_ram_addr] <= b_ram_wdata;
            p1 <= mem2[b_ram_addr];
            p2 <= p1;
        end
    end
    assign b_ram_rdata = p2;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Present one request, wait for its handshake, then scramble the inputs.
    task automatic issue(input bit sel, input int id, input logic we,
                         input logic [4:0] a, input logic [7:0] d, output int t_hs);
        t_hs = -1;
        if (!sel) begin
            req_we[id] = we; req_addr[id*5 +: 5] = a; req_wdata[id*8 +: 8] = d; req_valid[id] = 1'b1;
        end else begin
            b_we[id] = we; b_addr[id*5 +: 5] = a; b_wdata[id*8 +: 8] = d; b_valid[id] = 1'b1;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!sel ? (req_valid[id] && req_ready[id]) : (b_valid[id] && b_ready[id])) begin
                t_hs = cyc;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!sel) begin
            req_valid[id] = 1'b0; req_we[id] = ~we;
            req_addr[id*5 +: 5] = 5'($urandom); req_wdata[id*8 +: 8] = 8'($urandom);
        end else begin
            b_valid[id] = 1'b0; b_we[id] = ~we;
            b_addr[id*5 +: 5] = 5'($urandom); b_wdata[id*8 +: 8] = 8'($urandom);
        end
    endtask

    // Wait (bounded) for the next response pulse; t = -1 if none arrives.
    task automatic wait_rsp(input bit sel, output int t, output logic [1:0] v, output logic [7:0] d);
        t = -1; v = '0; d = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if ((sel ? b_rsp_valid : rsp_valid) != 2'b00) begin
                t = cyc;
                v = sel ? b_rsp_valid : rsp_valid;
                d = sel ? b_rsp_rdata : rsp_rdata;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({req_ready, rsp_valid, rsp_rdata} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_hs: got %h expected 000", {req_ready, rsp_valid, rsp_rdata});
        end
        n_checks++;
        if ({ram_wena, ram_addr, ram_wdata} !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_ram: got %h expected 0", {ram_wena, ram_addr, ram_wdata});
        end
        n_checks++;
        if ({b_ready, b_rsp_valid, b_rsp_rdata, b_ram_wena, b_ram_addr, b_ram_wdata} !== 26'h0) begin
            n_fail++;
            $display("FAIL reset_b: got %h expected 0",
                     {b_ready, b_rsp_valid, b_rsp_rdata, b_ram_wena, b_ram_addr, b_ram_wdata});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (req_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_ready: got %b expected 00", req_ready);
        end
    endtask

    task automatic test_write_read();
        int t, tr;
        logic [1:0] v;
        logic [7:0] d;
        issue(1'b0, 0, 1'b1, 5'h12, 8'h9F, t);
        wait_rsp(1'b0, tr, v, d);
        n_checks++;
        if (tr !== t + 2) begin n_fail++; $display("FAIL wr_latency: got %0d expected %0d", tr, t + 2); end
        n_checks++;
        if (v !== 2'b01) begin n_fail++; $display("FAIL wr_rsp_valid: got %b expected 01", v); end
        n_checks++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL wr_rsp_rdata: got %h expected 00", d); end
        issue(1'b0, 1, 1'b0, 5'h12, 8'h00, t);
        wait_rsp(1'b0, tr, v, d);
        n_checks++;
        if (tr !== t + 2) begin n_fail++; $display("FAIL rd_latency: got %0d expected %0d", tr, t + 2); end
        n_checks++;
        if (v !== 2'b10) begin n_fail++; $display("FAIL rd_rsp_valid: got %b expected 10", v); end
        n_checks++;
        if (d !== 8'h9F) begin n_fail++; $display("FAIL rd_rsp_rdata: got %h expected 9f", d); end
    endtask

    task automatic test_simultaneous();
        logic [1:0] hs_g [4];
        int         hs_c [4];
        int         wc   [4];
        logic [1:0] exp_g [4];
        int         nh, nw, r1;
        bit         exp_r1_zero;
`ifdef RAM_ARB_FIXED_PRIO_EN
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
        exp_r1_zero = 1'b1;
`else
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_r1_zero = 1'b0;
`endif
        for (int i = 0; i < 4; i++) begin hs_g[i] = '0; hs_c[i] = -100; wc[i] = -100; end
        nh = 0; nw = 0; r1 = 0;
        rst_n = 1'b0;
        @(negedge clk);
        req_we = 2'b11;
        req_addr = {5'h04, 5'h03};
        req_wdata = {8'h44, 8'h33};
        req_valid = 2'b11;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 2'b00) begin n_fail++; $display("FAIL sim_ready_in_reset: got %b expected 00", req_ready); end
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if ((req_valid & req_ready) != 2'b00 && nh < 4) begin
                hs_g[nh] = req_valid & req_ready;
                hs_c[nh] = cyc;
                nh++;
            end
            if (ram_wena) begin
                if (nw < 4) wc[nw] = cyc;
                nw++;
            end
            if (req_ready[1]) r1++;
        end
        req_valid = 2'b00;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (hs_g[i] !== exp_g[i]) begin
                n_fail++;
                $display("FAIL sim_grant%0d: got %b expected %b", i, hs_g[i], exp_g[i]);
            end
            n_checks++;
            if (wc[i] !== hs_c[i] + 1) begin
                n_fail++;
                $display("FAIL sim_wena%0d: got cycle %0d expected %0d", i, wc[i], hs_c[i] + 1);
            end
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (hs_c[i+1] - hs_c[i] !== 3) begin
                n_fail++;
                $display("FAIL sim_spacing%0d: got %0d expected 3", i, hs_c[i+1] - hs_c[i]);
            end
        end
        n_checks++;
        if ((r1 == 0) !== exp_r1_zero) begin
            n_fail++;
            $display("FAIL sim_ready1: got %0d cycles, expected none=%0d", r1, exp_r1_zero);
        end
        n_checks++;
        if (mem0[3] !== 8'h33) begin n_fail++; $display("FAIL sim_mem3: got %h expected 33", mem0[3]); end
    endtask

    task automatic test_addr_boundary();
        int t, tr;
        logic [1:0] v;
        logic [7:0] d;
        issue(1'b0, 0, 1'b1, 5'h1F, 8'hFF, t);
        wait_rsp(1'b0, tr, v, d);
        issue(1'b0, 1, 1'b1, 5'h00, 8'h00, t);
        wait_rsp(1'b0, tr, v, d);
        n_checks++;
        if (v !== 2'b10) begin n_fail++; $display("FAIL bnd_wr_valid: got %b expected 10", v); end
        issue(1'b0, 0, 1'b0, 5'h1F, 8'h00, t);
        wait_rsp(1'b0, tr, v, d);
        n_checks++;
        if (d !== 8'hFF) begin n_fail++; $display("FAIL bnd_rd_1f: got %h expected ff", d); end
        n_checks++;
        if (tr !== t + 2) begin n_fail++; $display("FAIL bnd_rd_1f_lat: got %0d expected %0d", tr, t + 2); end
        issue(1'b0, 1, 1'b0, 5'h00, 8'h00, t);
        wait_rsp(1'b0, tr, v, d);
        n_checks++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL bnd_rd_00: got %h expected 00", d); end
        n_checks++;
        if (v !== 2'b10) begin n_fail++; $display("FAIL bnd_rd_00_valid: got %b expected 10", v); end
    endtask

    task automatic test_read_latency();
        int t, tr;
        logic [1:0] v;
        logic [7:0] d;
        issue(1'b1, 0, 1'b1, 5'h05, 8'h3C, t);
        wait_rsp(1'b1, tr, v, d);
        n_checks++;
        if (tr !== t + 2) begin n_fail++; $display("FAIL lat_wr: got %0d expected %0d", tr, t + 2); end
        issue(1'b1, 1, 1'b1, 5'h06, 8'h11, t);
        wait_rsp(1'b1, tr, v, d);
        issue(1'b1, 0, 1'b0, 5'h05, 8'h00, t);
        wait_rsp(1'b1, tr, v, d);
        n_checks++;
        if (tr !== t + 4) begin n_fail++; $display("FAIL lat_rd: got %0d expected %0d", tr, t + 4); end
        n_checks++;
        if (v !== 2'b01) begin n_fail++; $display("FAIL lat_rd_valid: got %b expected 01", v); end
        n_checks++;
        if (d !== 8'h3C) begin n_fail++; $display("FAIL lat_rd_data: got %h expected 3c", d); end
    endtask

    task automatic test_reset_mid_read();
        int t, seen;
        issue(1'b1, 1, 1'b0, 5'h06, 8'h00, t);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if ({b_ready, b_rsp_valid, b_rsp_rdata} !== 12'h000) begin
            n_fail++;
            $display("FAIL mid_rst_hs: got %h expected 000", {b_ready, b_rsp_valid, b_rsp_rdata});
        end
        n_checks++;
        if ({b_ram_wena, b_ram_addr, b_ram_wdata} !== 14'h0) begin
            n_fail++;
            $display("FAIL mid_rst_ram: got %h expected 0", {b_ram_wena, b_ram_addr, b_ram_wdata});
        end
        n_checks++;
        if (b_dut.state !== ram_arb_pkg::IDLE) begin
            n_fail++;
            $display("FAIL mid_rst_state: got %0d expected %0d", b_dut.state, ram_arb_pkg::IDLE);
        end
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (b_rsp_valid != 2'b00) seen++;
        end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL mid_rst_no_rsp: got %0d pulses expected 0", seen); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_addr_boundary();
        test_read_latency();
        test_reset_mid_read();
        test_simultaneous();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
